multi_race_observer: RTL

N-channel generalisation of the single-channel start/done race observer. Each channel runs an independent four-phase handshake: start rises, the block waits a delay, done rises, start falls, done falls. The delay is either random, from an internal free-running LFSR, or a programmed fixed value. The block also arbitrates which channel finished first in each race, and flags channels whose requester withdraws start before done.

---
 rtl/multi_race_observer.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/multi_race_observer.sv
// multi_race_observer: N independent four-phase start/done handshake channels.
// Each channel waits either a programmed delay or an LFSR-derived random delay
// before raising done, reports requester withdrawal as a one-cycle abort pulse,
// and a shared arbiter records the lowest-index channel to finish each race.
module multi_race_observer #(
   parameter int unsigned        N_CH       = 4,
   parameter int unsigned        LFSR_W     = 8,
   parameter logic [LFSR_W-1:0]  LFSR_TAPS  = 8'hB8,
   parameter logic [LFSR_W-1:0]  SEED       = 8'h5A,
   parameter int unsigned        DELAY_MIN  = 2,
   parameter logic [LFSR_W-1:0]  DELAY_MASK = 8'h0F,
   parameter int unsigned        CNT_W      = 9,
   localparam int unsigned       WID_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic             clk,
   input  logic             rst_l,
   input  logic             fixed_mode,
   input  logic [CNT_W-1:0] fixed_delay,
   input  logic [N_CH-1:0]  start,
   output logic [N_CH-1:0]  done,
   output logic [N_CH-1:0]  abort,
   output logic             winner_valid,
   output logic [WID_W-1:0] winner_id,
   output logic             busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_DONE = 2'b10
   } ch_state_t;

   // A zero seed would lock the LFSR, so it is replaced by 1.
   localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == '0) ? LFSR_W'(1) : SEED;

   logic [LFSR_W-1:0] lfsr_q;
   ch_state_t         state_q [N_CH];
   ch_state_t         state_d [N_CH];
   logic [CNT_W-1:0]  cnt_q   [N_CH];
   logic [CNT_W-1:0]  cnt_d   [N_CH];
   logic [N_CH-1:0]   abort_d;
   logic [N_CH-1:0]   enter_done;
   logic [WID_W-1:0]  first_id;

   // Counter preload (delay minus one) for a channel accepting a new request.
   function automatic logic [CNT_W-1:0] load_value(
      input logic [LFSR_W-1:0] lfsr,
      input int unsigned       ch,
      input logic              fmode,
      input logic [CNT_W-1:0]  fdly
   );
      logic [LFSR_W-1:0] span;
      logic [CNT_W-1:0]  dly;
      span = (lfsr ^ LFSR_W'(ch)) & DELAY_MASK;
      if (fmode) begin
         dly = (fdly == '0) ? CNT_W'(1) : fdly;
      end else begin
         dly = CNT_W'(DELAY_MIN + 32'(span));
      end
      return dly - CNT_W'(1);
   endfunction

   // Free-running Galois LFSR, right-shifting with feedback from bit 0.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         lfsr_q <= SEED_EFF;
      end else if (lfsr_q[0]) begin
         lfsr_q <= (lfsr_q >> 1) ^ LFSR_TAPS;
      end else begin
         lfsr_q <= lfsr_q >> 1;
      end
   end

   // Per-channel next-state, counter and abort decode.
   always_comb begin
      abort_d    = '0;
      enter_done = '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         case (state_q[i])
            S_IDLE: begin
               if (start[i]) begin
                  state_d[i] = S_RUN;
                  cnt_d[i]   = load_value(lfsr_q, i, fixed_mode, fixed_delay);
               end
            end
            S_RUN: begin
               // Withdrawal wins over an expiring counter on the same edge.
               if (!start[i]) begin
                  state_d[i] = S_IDLE;
                  cnt_d[i]   = '0;
                  abort_d[i] = 1'b1;
               end else if (cnt_q[i] == '0) begin
                  state_d[i]    = S_DONE;
                  enter_done[i] = 1'b1;
               end else begin
                  cnt_d[i] = cnt_q[i] - CNT_W'(1);
               end
            end
            S_DONE: begin
               if (!start[i]) begin
                  state_d[i] = S_IDLE;
               end
            end
            default: begin
               state_d[i] = S_IDLE;
               cnt_d[i]   = '0;
            end
         endcase
      end
   end

   // Channel state, counters and the registered abort pulse.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         for (int unsigned i = 0; i < N_CH; i++) begin
            state_q[i] <= S_IDLE;
            cnt_q[i]   <= '0;
         end
         abort <= '0;
      end else begin
         for (int unsigned i = 0; i < N_CH; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
         abort <= abort_d;
      end
   end

   // done and busy decode straight from channel state.
   always_comb begin
      done = '0;
      busy = 1'b0;
      for (int unsigned i = 0; i < N_CH; i++) begin
         done[i] = (state_q[i] == S_DONE);
         if (state_q[i] != S_IDLE) begin
            busy = 1'b1;
         end
      end
   end

   // Lowest-index channel entering DONE this edge.
   always_comb begin
      first_id = '0;
      for (int unsigned k = N_CH; k > 0; k--) begin
         if (enter_done[k-1]) begin
            first_id = WID_W'(k - 1);
         end
      end
   end

   // Race arbiter: first finisher latches, cleared once every channel is idle and released.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         winner_valid <= 1'b0;
         winner_id    <= '0;
      end else if (!winner_valid && (enter_done != '0)) begin
         winner_valid <= 1'b1;
         winner_id    <= first_id;
      end else if (!busy && (start == '0)) begin
         winner_valid <= 1'b0;
         winner_id    <= '0;
      end
   end

endmodule
